fu_issue_ctrl: RTL
==================

// Module: fu_issue_ctrl
// PURPOSE
//  Parametrised issue stage between the reservation station and NUM_FU function units (ALU/MUL/DIV/...).
//  Accepts one RS entry per cycle when the selected FU is ready and not busy, then registers the operands onto a shared issue bus.
//  Pulses a per-FU valid signal for that entry.
//  Tracks a busy bit per multi-cycle FU, set at issue and cleared on that FU's done. A same-FU back-to-back issue cannot be lost.
// PARAMETERS
//  XLEN        32      operand/store-data width
//  TAG_W       3       RS tag width
//  CTRL_W      3       ALU control width
//  NUM_FU      3       number of function units (index 0 = ALU, 1 = MUL, 2 = DIV by default)
//  FU_SEL_W    2       width of rs_fu_sel, >= clog2(NUM_FU)
//  MC_MASK     3'b110  bit i = 1: FU i is multi-cycle and busy-tracked
// PORTS
//  clk_i         in   1            clock
//  reset_i       in   1            synchronous active-high reset
//  recover_en    in   1            branch-mispredict flush
//  rs_valid      in   1            RS presents an entry
//  rs_fu_sel     in   FU_SEL_W     target FU index
//  rs_alu_ctrl   in   CTRL_W       ALU op
//  rs_br_type    in   2            branch type
//  rs_is_load/rs_is_store/rs_is_branch  in  1 each  op flags
//  rs_vj, rs_vk  in   XLEN         operands
//  rs_store_data in   XLEN         store data
//  rs_tag        in   TAG_W        RS tag
//  rs_ready      out  1            entry accepted this cycle (combinational)
//  fu_ready      in   NUM_FU       FU i can take an op
//  fu_done       in   NUM_FU       FU i completed its op (1-cycle pulse)
//  fu_valid      out  NUM_FU       one-hot issue pulse
//  iss_alu_ctrl, iss_br_type, iss_is_load, iss_is_store, iss_is_branch, iss_vj, iss_vk, iss_store_data, iss_tag
//                out  as rs_*      registered issue bus
//  fu_busy       out  NUM_FU       busy bits (debug/RS scheduling)
//  illegal_sel   out  1            1-cycle pulse: rs_valid with rs_fu_sel >= NUM_FU
// BEHAVIOUR
//  Reset (reset_i=1 at posedge)
//   - fu_valid, fu_busy, illegal_sel and all iss_* outputs are 0.
//   - reset_i has priority over every other input.
//  Acceptance (combinational)
//   - accept = rs_valid & !recover_en & sel_legal & fu_ready[sel] & !blocked[sel].
//   - blocked[sel] = fu_busy[sel] & !fu_done[sel]. A done in the same cycle unblocks, so back-to-back issue is allowed.
//   - rs_ready = accept.
//   - Non-MC FUs are never blocked by busy; only fu_ready gates them.
//  Issue (1-cycle latency)
//   - On accept at edge N: fu_valid[sel]=1 for exactly the cycle after N, and the iss_* bus loads rs_*.
//   - Without accept, fu_valid=0 and iss_* holds its last value.
//   - The FU must sample iss_* while its fu_valid bit is high.
//  Busy update, per MC FU i, each edge
//   - Issue to i: busy=1. Issue has priority over a simultaneous done.
//   - Else fu_done[i]: busy=0.
//   - Else hold.
//   - fu_done on a non-busy FU is ignored.
//  Flush (recover_en=1 at edge)
//   - fu_valid, fu_busy and iss_* are cleared.
//   - No accept that cycle, even if rs_valid=1.
//   - FUs squash internally, so a later done is ignored.
//  Illegal select
//   - rs_valid & rs_fu_sel >= NUM_FU: rs_ready=0 and illegal_sel pulses on the next cycle. No state change.
//  Width rules: no arithmetic. All buses pass through at parameter widths, and one-hot fu_valid is NUM_FU bits.
// TESTING
//  1. Reset: hold reset_i 2 cycles with rs_valid=1 -> fu_valid=0, fu_busy=0, iss_vj=0, rs_ready=0.
//  2. ALU stream: rs_fu_sel=0, fu_ready=3'b111, 4 consecutive entries vj=1..4 -> rs_ready high 4 cycles, fu_valid=3'b001 each next cycle, iss_vj=1,2,3,4.
//  3. MUL busy: issue MUL (tag=5) -> fu_busy=3'b010. A second MUL is held with rs_ready=0 until fu_done[1]. It is accepted in the fu_done cycle and fu_busy stays 3'b010.
//  4. Flush: MUL and DIV busy, rs_valid=1 with recover_en=1 -> rs_ready=0, next cycle fu_busy=0, fu_valid=0, iss_tag=0.
//  5. Illegal: rs_valid=1, rs_fu_sel=3 (NUM_FU=3) -> rs_ready=0, illegal_sel=1 for one cycle, fu_valid=0.
//  6. Ready gating: rs_fu_sel=2, fu_ready[2]=0 for 3 cycles, then 1 -> accept only on cycle 4, and fu_valid=3'b100 on cycle 5.

Source files
------------

// File: rtl/fu_issue_ctrl.sv
// Issue stage between the reservation station and NUM_FU function units:
// one-entry-per-cycle accept, registered issue bus, one-hot fu_valid pulse, per-FU busy tracking.

module fu_busy_bit (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_flush,
  input  logic i_issue,
  input  logic i_done,
  output logic o_busy
);
  // Issue wins over a same-cycle done so a back-to-back op keeps the FU busy.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) o_busy <= 1'b0;
    else if (i_issue)     o_busy <= 1'b1;
    else if (i_done)      o_busy <= 1'b0;
  end
endmodule

module fu_issue_ctrl #(
  parameter int               XLEN     = 32,
  parameter int               TAG_W    = 3,
  parameter int               CTRL_W   = 3,
  parameter int               NUM_FU   = 3,
  parameter int               FU_SEL_W = 2,
  parameter logic [NUM_FU-1:0] MC_MASK = 3'b110
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                recover_en,
  input  logic                rs_valid,
  input  logic [FU_SEL_W-1:0] rs_fu_sel,
  input  logic [CTRL_W-1:0]   rs_alu_ctrl,
  input  logic [1:0]          rs_br_type,
  input  logic                rs_is_load,
  input  logic                rs_is_store,
  input  logic                rs_is_branch,
  input  logic [XLEN-1:0]     rs_vj,
  input  logic [XLEN-1:0]     rs_vk,
  input  logic [XLEN-1:0]     rs_store_data,
  input  logic [TAG_W-1:0]    rs_tag,
  output logic                rs_ready,
  input  logic [NUM_FU-1:0]   fu_ready,
  input  logic [NUM_FU-1:0]   fu_done,
  output logic [NUM_FU-1:0]   fu_valid,
  output logic [CTRL_W-1:0]   iss_alu_ctrl,
  output logic [1:0]          iss_br_type,
  output logic                iss_is_load,
  output logic                iss_is_store,
  output logic                iss_is_branch,
  output logic [XLEN-1:0]     iss_vj,
  output logic [XLEN-1:0]     iss_vk,
  output logic [XLEN-1:0]     iss_store_data,
  output logic [TAG_W-1:0]    iss_tag,
  output logic [NUM_FU-1:0]   fu_busy,
  output logic                illegal_sel
);
  typedef struct packed {
    logic [CTRL_W-1:0] alu_ctrl;
    logic [1:0]        br_type;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic [XLEN-1:0]   vj;
    logic [XLEN-1:0]   vk;
    logic [XLEN-1:0]   store_data;
    logic [TAG_W-1:0]  tag;
  } iss_t;

  logic [NUM_FU-1:0] w_sel_oh, w_blocked, w_issue;
  logic              w_sel_legal, w_accept;
  iss_t              w_rs, r_iss;

  // Out-of-range selects decode to all-zero, which doubles as the legality check.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_dec
    assign w_sel_oh[i] = (rs_fu_sel == FU_SEL_W'(i));
  end
  assign w_sel_legal = |w_sel_oh;
  assign w_blocked   = fu_busy & ~fu_done;
  assign w_accept    = ~reset_i & rs_valid & ~recover_en &
                       (|(w_sel_oh & fu_ready & ~w_blocked));
  assign w_issue     = w_accept ? w_sel_oh : '0;
  assign rs_ready    = w_accept;

  assign w_rs = '{alu_ctrl: rs_alu_ctrl, br_type: rs_br_type, is_load: rs_is_load,
                  is_store: rs_is_store, is_branch: rs_is_branch, vj: rs_vj, vk: rs_vk,
                  store_data: rs_store_data, tag: rs_tag};

  always_ff @(posedge clk_i) begin
    if (reset_i || recover_en) begin
      fu_valid <= '0;
      r_iss    <= '0;
    end else begin
      fu_valid <= w_issue;
      if (w_accept) r_iss <= w_rs;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) illegal_sel <= 1'b0;
    else         illegal_sel <= rs_valid & ~w_sel_legal;
  end

  for (genvar i = 0; i < NUM_FU; i++) begin : g_busy
    if (MC_MASK[i]) begin : g_mc
      fu_busy_bit u_busy (
        .i_clk  (clk_i),
        .i_rst  (reset_i),
        .i_flush(recover_en),
        .i_issue(w_issue[i]),
        .i_done (fu_done[i]),
        .o_busy (fu_busy[i])
      );
    end else begin : g_sc
      assign fu_busy[i] = 1'b0;
    end
  end

  assign iss_alu_ctrl   = r_iss.alu_ctrl;
  assign iss_br_type    = r_iss.br_type;
  assign iss_is_load    = r_iss.is_load;
  assign iss_is_store   = r_iss.is_store;
  assign iss_is_branch  = r_iss.is_branch;
  assign iss_vj         = r_iss.vj;
  assign iss_vk         = r_iss.vk;
  assign iss_store_data = r_iss.store_data;
  assign iss_tag        = r_iss.tag;
endmodule
